cin: RTL and testbench

Nibble-serial SHA-256 message-schedule front end. It loads one 512-bit message block four bits per clock. It then expands the block into schedule words W16..W63, one word per clock, and presents σ0, σ1 and the new word Wt for inspection and for the compression datapath. After each block it loops automatically to load the next one.

---
 rtl/cin.sv | 92 +++++++++
 tb/tb_cin.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cin.sv
// Nibble-serial SHA-256 message-schedule front end: loads a 512-bit block
// four bits per clock, then expands W16..W63 one word per clock.
module cin (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  din,
  output logic [3:0]  out,
  output logic [31:0] s0,
  output logic [31:0] s1,
  output logic [31:0] exp
);

  localparam logic [1:0] LOAD   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]   state;
  logic [6:0]   cnt;
  logic [5:0]   t;
  logic [511:0] win;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Window slot j holds W[t-16+j]; slot 0 sits in the top 32 bits.
  logic [31:0] w_tm16, w_tm15, w_tm7, w_tm2;
  logic [31:0] sig0_p0, sig1_p0, wt_p0;

  assign w_tm16  = win[511:480];
  assign w_tm15  = win[479:448];
  assign w_tm7   = win[223:192];
  assign w_tm2   = win[63:32];
  assign sig0_p0 = sigma0(w_tm15);
  assign sig1_p0 = sigma1(w_tm2);
  assign wt_p0   = sig1_p0 + w_tm7 + sig0_p0 + w_tm16;

  // Stage p0 -> output registers; out reports the state that was active at this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      cnt   <= 7'd0;
      t     <= 6'd16;
      win   <= '0;
      s0    <= 32'h0;
      s1    <= 32'h0;
      exp   <= 32'h0;
      out   <= 4'b0001;
    end else begin
      case (state)
        LOAD: begin
          out <= 4'b0001;
          win <= {win[507:0], din};
          cnt <= cnt + 7'd1;
          if (cnt == 7'd127) begin
            state <= EXPAND;
            t     <= 6'd16;
          end
        end
        EXPAND: begin
          out <= 4'b0010;
          win <= {win[479:0], wt_p0};
          s0  <= sig0_p0;
          s1  <= sig1_p0;
          exp <= wt_p0;
          if (t == 6'd63) state <= DONE;
          else            t     <= t + 6'd1;
        end
        DONE: begin
          out   <= 4'b0100;
          state <= LOAD;
          cnt   <= 7'd0;
          t     <= 6'd16;
        end
        default: begin
          state <= LOAD;
          cnt   <= 7'd0;
          t     <= 6'd16;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cin.sv
// Directed bench for the cin message-schedule front end.
module tb_cin;
  logic        clk;
  logic        rst;
  logic [3:0]  din;
  logic [3:0]  out;
  logic [31:0] s0, s1, exp;

  cin dut (
    .clk(clk), .rst(rst), .din(din), .out(out), .s0(s0), .s1(s1), .exp(exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_fail;
  int edge_cnt;

  logic [31:0] wm [0:63];
  logic [31:0] m0 [0:63];
  logic [31:0] m1 [0:63];

  localparam logic [511:0] ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] NINES = {128{4'h9}};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic build_model(input logic [511:0] b);
    for (int i = 0; i < 16; i++) wm[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      m0[i] = ror(wm[i-15], 7) ^ ror(wm[i-15], 18) ^ (wm[i-15] >> 3);
      m1[i] = ror(wm[i-2], 17) ^ ror(wm[i-2], 19) ^ (wm[i-2] >> 10);
      wm[i] = m1[i] + wm[i-7] + m0[i] + wm[i-16];
    end
  endtask

  task automatic step(input logic [3:0] nib);
    din = nib;
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (5) step(4'h0);
    rst = 1'b0;
    edge_cnt = 0;
  endtask

  task automatic load_block(input logic [511:0] b);
    for (int i = 0; i < 128; i++) step(b[511 - 4*i -: 4]);
  endtask

  task automatic check_expand_all(input string tag);
    for (int t = 16; t < 64; t++) begin
      step(4'h0);
      n_cmp++;
      if (exp !== wm[t] || s0 !== m0[t] || s1 !== m1[t] || out !== 4'b0010) begin
        n_fail++;
        $display("FAIL %s t=%0d edge=%0d: got exp=%h s0=%h s1=%h out=%b, want exp=%h s0=%h s1=%h out=0010",
                 tag, t, edge_cnt, exp, s0, s1, out, wm[t], m0[t], m1[t]);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (out !== 4'b0001 || s0 !== 32'h0 || s1 !== 32'h0 || exp !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: got out=%b s0=%h s1=%h exp=%h, want 0001/0/0/0", out, s0, s1, exp);
    end
    for (int i = 0; i < 128; i++) begin
      step(4'hA);
      n_cmp++;
      if (out !== 4'b0001 || s0 !== 32'h0 || s1 !== 32'h0 || exp !== 32'h0) begin
        n_fail++;
        $display("FAIL load_hold edge=%0d: got out=%b s0=%h s1=%h exp=%h, want 0001/0/0/0",
                 edge_cnt, out, s0, s1, exp);
      end
    end
  endtask

  task automatic test_nines();
    do_reset();
    load_block(NINES);
    step(4'h0);
    n_cmp++;
    if (s0 !== 32'h46666666 || s1 !== 32'hFFD99999 || exp !== 32'h79733331 || out !== 4'b0010) begin
      n_fail++;
      $display("FAIL nines_w16: got s0=%h s1=%h exp=%h out=%b, want 46666666 ffd99999 79733331 0010",
               s0, s1, exp, out);
    end
    step(4'h0);
    n_cmp++;
    if (exp !== 32'h79733331) begin
      n_fail++;
      $display("FAIL nines_w17: got exp=%h, want 79733331", exp);
    end
  endtask

  task automatic test_zero();
    do_reset();
    load_block(512'h0);
    for (int t = 16; t < 64; t++) begin
      step(4'h0);
      n_cmp++;
      if (exp !== 32'h0 || s0 !== 32'h0 || s1 !== 32'h0) begin
        n_fail++;
        $display("FAIL zero_word t=%0d: got exp=%h s0=%h s1=%h, want 0", t, exp, s0, s1);
      end
    end
    step(4'h0);
    n_cmp++;
    if (out !== 4'b0100 || edge_cnt != 177) begin
      n_fail++;
      $display("FAIL zero_done: got out=%b at edge %0d, want 0100 at 177", out, edge_cnt);
    end
    step(4'h0);
    n_cmp++;
    if (out !== 4'b0001) begin
      n_fail++;
      $display("FAIL zero_reload: got out=%b at edge %0d, want 0001", out, edge_cnt);
    end
  endtask

  task automatic test_abc();
    build_model(ABC);
    do_reset();
    load_block(ABC);
    check_expand_all("abc");
    n_cmp++;
    if (wm[16] !== 32'h61626380 || wm[63] !== 32'h12B1EDEB) begin
      n_fail++;
      $display("FAIL abc_model: got w16=%h w63=%h, want 61626380 12b1edeb", wm[16], wm[63]);
    end
    n_cmp++;
    if (exp !== 32'h12B1EDEB) begin
      n_fail++;
      $display("FAIL abc_w63: got exp=%h, want 12b1edeb", exp);
    end
    step(4'hF);
    n_cmp++;
    if (out !== 4'b0100 || exp !== 32'h12B1EDEB || s0 !== m0[63] || s1 !== m1[63]) begin
      n_fail++;
      $display("FAIL abc_done_hold: got out=%b exp=%h s0=%h s1=%h, want 0100 12b1edeb %h %h",
               out, exp, s0, s1, m0[63], m1[63]);
    end
    step(4'hF);
    n_cmp++;
    if (out !== 4'b0001 || exp !== 32'h12B1EDEB) begin
      n_fail++;
      $display("FAIL abc_load_hold: got out=%b exp=%h, want 0001 12b1edeb", out, exp);
    end
  endtask

  task automatic test_reset_mid();
    build_model(ABC);
    do_reset();
    load_block(ABC);
    while (edge_cnt < 139) step(4'h0);
    rst = 1'b1;
    step(4'h0);
    n_cmp++;
    if (out !== 4'b0001 || s0 !== 32'h0 || s1 !== 32'h0 || exp !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got out=%b s0=%h s1=%h exp=%h, want 0001/0/0/0", out, s0, s1, exp);
    end
    rst = 1'b0;
    edge_cnt = 0;
    load_block(ABC);
    check_expand_all("abc_after_reset");
  endtask

  task automatic test_back_to_back();
    int e1, e2;
    logic [3:0] prev;
    logic [31:0] x1, x2;
    e1 = 0; e2 = 0; x1 = '0; x2 = '0;
    do_reset();
    prev = out;
    for (int k = 1; k <= 400; k++) begin
      if (k <= 128)                  step(ABC[511 - 4*(k-1) -: 4]);
      else if (k >= 178 && k <= 305) step(NINES[511 - 4*(k-178) -: 4]);
      else                           step(4'h0);
      if (out === 4'b0010 && prev !== 4'b0010) begin
        if (e1 == 0) begin e1 = edge_cnt; x1 = exp; end
        else if (e2 == 0) begin e2 = edge_cnt; x2 = exp; end
      end
      prev = out;
    end
    n_cmp++;
    if (e1 != 129 || x1 !== 32'h61626380) begin
      n_fail++;
      $display("FAIL b2b_first: got edge=%0d exp=%h, want 129 61626380", e1, x1);
    end
    n_cmp++;
    if (e2 - e1 != 177 || x2 !== 32'h79733331) begin
      n_fail++;
      $display("FAIL b2b_second: got gap=%0d exp=%h, want 177 79733331", e2 - e1, x2);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    edge_cnt = 0;
    rst = 1'b1;
    din = 4'h0;
    test_reset();
    test_nines();
    test_zero();
    test_abc();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
